// File: rtl/option_store_ctrl_pkg.sv
// Shared types and sizes for the option store controller.
// Line indices cover rows first, then columns.
package option_store_ctrl_pkg;

  localparam int MAX_DIM = 11;
  localparam int OPT_W   = 16;
  localparam int ADDR_W  = 10;
  localparam int CNT_W   = 7;
  localparam int NLINES  = 2 * MAX_DIM;
  localparam int LINE_W  = 5;

  typedef logic [LINE_W-1:0] line_idx_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [OPT_W-1:0]  opt_t;

  localparam line_idx_t NLINES_IDX = line_idx_t'(NLINES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READY,
    S_FETCH,
    S_STREAM
  } state_e;

  function automatic logic serve_phase(state_e s);
    return (s == S_READY) || (s == S_FETCH) || (s == S_STREAM);
  endfunction

endpackage

// File: rtl/option_store_ctrl_line_table.sv
// Per-line base address and option count table.
// One write port (count increment plus next-line base), one read port.
module line_table
  import option_store_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  line_idx_t wr_idx_i,
  input  logic      cnt_inc_i,
  input  logic      base_we_i,
  input  addr_t     base_wdata_i,
  output logic      cnt_sat_o,
  input  line_idx_t rd_idx_i,
  output addr_t     rd_base_o,
  output cnt_t      rd_cnt_o
);

  addr_t     base_q [NLINES];
  cnt_t      cnt_q  [NLINES];
  line_idx_t nxt_idx;

  // Closing line wr_idx opens line wr_idx+1 at the given base.
  assign nxt_idx = wr_idx_i + line_idx_t'(1);

  // Count increments and base writes for the line being loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NLINES; i++) begin
        base_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NLINES; i++) begin
        if (cnt_inc_i && (wr_idx_i == line_idx_t'(i)))
          cnt_q[i] <= cnt_q[i] + cnt_t'(1);
        if (base_we_i && (nxt_idx == line_idx_t'(i)))
          base_q[i] <= base_wdata_i;
      end
    end
  end

  // Read port and saturation flag; out-of-range indices read as empty.
  always_comb begin
    rd_base_o = '0;
    rd_cnt_o  = '0;
    cnt_sat_o = 1'b1;
    if (rd_idx_i < NLINES_IDX) begin
      rd_base_o = base_q[rd_idx_i];
      rd_cnt_o  = cnt_q[rd_idx_i];
    end
    if (wr_idx_i < NLINES_IDX)
      cnt_sat_o = &cnt_q[wr_idx_i];
  end

endmodule

// File: rtl/option_store_ctrl.sv
// Option store controller: loads parser options into the option RAM,
// then streams all options of a requested line back to the solver.
module option_store_ctrl
  import option_store_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      write_ready,
  input  opt_t      line,
  input  logic      line_done,
  input  logic      board_done,
  input  logic [3:0] n,
  input  logic [3:0] m,
  output logic      mem_we,
  output addr_t     mem_addr,
  output opt_t      mem_wdata,
  input  opt_t      mem_rdata,
  input  logic      req_valid,
  output logic      req_ready,
  input  line_idx_t req_line,
  output logic      opt_valid,
  output opt_t      opt_data,
  output logic      opt_last,
  output logic      resp_empty,
  output logic      load_done,
  output logic      error
);

  localparam logic [ADDR_W:0] PTR_ONE = 1;

  state_e          state_q, state_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  line_idx_t       cur_line_q, cur_line_d;
  cnt_t            rem_q, rem_d;
  logic            err_q, err_d;
  logic            we_q, we_d;
  logic            empty_q, empty_d;
  addr_t           addr_q, addr_d;
  opt_t            wdata_q, wdata_d;

  logic      tbl_inc, tbl_base_we, cnt_sat;
  addr_t     rd_base;
  cnt_t      rd_cnt;
  line_idx_t nm;
  logic      wr_ok, ld_ok, parser_any, accept, req_bad;

  assign nm = line_idx_t'(n) + line_idx_t'(m);

  // A write is dropped once the RAM, the line table or the count is full.
  assign wr_ok = write_ready && !wr_ptr_q[ADDR_W]
              && (cur_line_q < NLINES_IDX) && !cnt_sat;
  assign ld_ok = line_done && (cur_line_q < NLINES_IDX);
  assign parser_any = write_ready | line_done | board_done;

  assign req_ready = (state_q == S_READY) && !empty_q;
  assign accept    = req_ready && req_valid;
  assign req_bad   = (req_line >= nm) || (req_line >= NLINES_IDX)
                  || (rd_cnt == '0);

  line_table u_table (
    .clk          (clk),
    .rst          (rst),
    .wr_idx_i     (cur_line_q),
    .cnt_inc_i    (tbl_inc),
    .base_we_i    (tbl_base_we),
    .base_wdata_i (wr_ptr_d[ADDR_W-1:0]),
    .cnt_sat_o    (cnt_sat),
    .rd_idx_i     (req_line),
    .rd_base_o    (rd_base),
    .rd_cnt_o     (rd_cnt)
  );

  // Next-state, pointer and RAM-port logic for load and serve phases.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cur_line_d  = cur_line_q;
    rem_d       = rem_q;
    err_d       = err_q;
    we_d        = 1'b0;
    empty_d     = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    tbl_inc     = 1'b0;
    tbl_base_we = 1'b0;
    unique case (state_q)
      S_IDLE, S_LOAD: begin
        if (parser_any)
          state_d = S_LOAD;
        if (write_ready) begin
          if (wr_ok) begin
            we_d     = 1'b1;
            addr_d   = wr_ptr_q[ADDR_W-1:0];
            wdata_d  = line;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            tbl_inc  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        if (line_done) begin
          if (ld_ok) begin
            cur_line_d  = cur_line_q + line_idx_t'(1);
            tbl_base_we = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        if (board_done) begin
          state_d = S_READY;
          if (cur_line_d != nm)
            err_d = 1'b1;
        end
      end
      S_READY: begin
        if (parser_any)
          err_d = 1'b1;
        if (accept) begin
          if (req_bad) begin
            empty_d = 1'b1;
          end else begin
            state_d = S_FETCH;
            addr_d  = rd_base;
            rem_d   = rd_cnt;
          end
        end
      end
      S_FETCH: begin
        if (parser_any)
          err_d = 1'b1;
        if (rem_q > cnt_t'(1))
          addr_d = addr_q + addr_t'(1);
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (parser_any)
          err_d = 1'b1;
        if (rem_q > cnt_t'(2))
          addr_d = addr_q + addr_t'(1);
        rem_d = rem_q - cnt_t'(1);
        if (rem_q == cnt_t'(1))
          state_d = S_READY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered RAM-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      cur_line_q <= '0;
      rem_q      <= '0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      empty_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      cur_line_q <= cur_line_d;
      rem_q      <= rem_d;
      err_q      <= err_d;
      we_q       <= we_d;
      empty_q    <= empty_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign opt_valid  = (state_q == S_STREAM);
  assign opt_last   = opt_valid && (rem_q == cnt_t'(1));
  assign opt_data   = opt_valid ? mem_rdata : '0;
  assign resp_empty = empty_q;
  assign load_done  = serve_phase(state_q);
  assign error      = err_q;

endmodule

// File: tb/tb_option_store_ctrl.sv
// Scoreboard bench for option_store_ctrl with a behavioural option RAM.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_option_store_ctrl;
  import option_store_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       write_ready, line_done, board_done;
  logic [15:0] line;
  logic [3:0] n, m;
  logic       mem_we;
  logic [9:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic       req_valid, req_ready;
  logic [4:0] req_line;
  logic       opt_valid, opt_last, resp_empty, load_done, error;
  logic [15:0] opt_data;

  typedef struct { logic [9:0] a; logic [15:0] d; } wr_t;
  typedef struct { logic [15:0] d; logic l; } op_t;

  wr_t wq[$];
  op_t oq[$];
  int  eq_n;
  wr_t we_e;
  op_t oe;
  logic [9:0] exp_wp;
  int checks = 0;
  int failures = 0;

  logic [15:0] ram [1024];
  logic [15:0] rdata_q;

  always #5 clk = ~clk;

  option_store_ctrl dut (
    .clk(clk), .rst(rst),
    .write_ready(write_ready), .line(line),
    .line_done(line_done), .board_done(board_done),
    .n(n), .m(m),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_line(req_line),
    .opt_valid(opt_valid), .opt_data(opt_data),
    .opt_last(opt_last), .resp_empty(resp_empty),
    .load_done(load_done), .error(error)
  );

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    rdata_q <= ram[mem_addr];
  end
  assign mem_rdata = rdata_q;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        chk("wr_pending", 32'(wq.size() > 0), 1);
        if (wq.size() > 0) begin
          we_e = wq.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(we_e.a));
          chk("wr_data", 32'(mem_wdata), 32'(we_e.d));
        end
      end
      if (opt_valid) begin
        chk("opt_pending", 32'(oq.size() > 0), 1);
        if (oq.size() > 0) begin
          oe = oq.pop_front();
          chk("opt_data", 32'(opt_data), 32'(oe.d));
          chk("opt_last", 32'(opt_last), 32'(oe.l));
        end
      end
      if (resp_empty) begin
        chk("empty_pending", 32'(eq_n > 0), 1);
        if (eq_n > 0) eq_n--;
      end
    end
  end

  task automatic clear_in();
    write_ready = 0; line_done = 0; board_done = 0; line = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    req_valid = 0; req_line = '0;
    wq.delete(); oq.delete(); eq_n = 0; exp_wp = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse(input logic wr, input logic [15:0] d,
                       input logic ld, input logic bd);
    write_ready = wr; line = d; line_done = ld; board_done = bd;
    if (wr) begin
      wq.push_back('{a: exp_wp, d: d});
      exp_wp = exp_wp + 10'd1;
    end
    @(posedge clk); #1;
    clear_in();
  endtask

  task automatic load_board_a();
    n = 4'd2; m = 4'd3;
    pulse(1, 16'h0007, 0, 0);
    pulse(0, 16'h0000, 1, 0);
    pulse(1, 16'h0000, 1, 0);
    for (int c = 0; c < 3; c++) begin
      pulse(1, 16'h0001, 0, 0);
      pulse(1, 16'h0002, 1, 0);
    end
    pulse(0, 16'h0000, 0, 1);
    chk("a_load_done", 32'(load_done), 1);
    chk("a_error", 32'(error), 0);
  endtask

  task automatic request(input logic [4:0] l, input int k,
                         input logic [9:0] base,
                         input logic [15:0] d0, input logic [15:0] d1,
                         input logic [15:0] d2, input logic [15:0] d3);
    logic [15:0] dv [4];
    int w;
    dv = '{d0, d1, d2, d3};
    req_valid = 1; req_line = l;
    w = 0;
    while (!req_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("req_ready_wait", 32'(req_ready), 1);
    if (k == 0) eq_n++;
    for (int i = 0; i < k; i++)
      oq.push_back('{d: dv[i], l: (i == k - 1)});
    @(posedge clk); #1;
    req_valid = 0;
    chk("rdy_t1", 32'(req_ready), 0);
    if (k == 0) begin
      chk("empty_t1", 32'(resp_empty), 1);
    end else begin
      chk("fetch_addr", 32'(mem_addr), 32'(base));
      @(posedge clk); #1;
      chk("first_valid", 32'(opt_valid), 1);
      repeat (k - 1) begin
        @(posedge clk); #1;
      end
      chk("last_at_t1k", 32'(opt_last), 1);
      chk("rdy_t1k", 32'(req_ready), 0);
    end
    @(posedge clk); #1;
    chk("rdy_after", 32'(req_ready), 1);
    chk("no_opt_after", 32'(opt_valid), 0);
  endtask

  task automatic requests_a();
    request(5'd0, 1, 10'd0, 16'h0007, 0, 0, 0);
    request(5'd1, 1, 10'd1, 16'h0000, 0, 0, 0);
    request(5'd2, 2, 10'd2, 16'h0001, 16'h0002, 0, 0);
    request(5'd3, 2, 10'd4, 16'h0001, 16'h0002, 0, 0);
    request(5'd4, 2, 10'd6, 16'h0001, 16'h0002, 0, 0);
    request(5'd5, 0, 10'd0, 0, 0, 0, 0);
    chk("a_err_after_req", 32'(error), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    int w;
    rst = 1'b1;
    clear_in();
    req_valid = 0; req_line = '0; n = '0; m = '0;
    eq_n = 0; exp_wp = '0;
    #3;
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_opt_valid", 32'(opt_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_load_done", 32'(load_done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_resp_empty", 32'(resp_empty), 0);

    // Full board, every line requested, plus an invalid index.
    do_reset();
    load_board_a();
    requests_a();

    // Option and line end in the same cycle, then back-to-back writes.
    do_reset();
    n = 4'd1; m = 4'd1;
    pulse(1, 16'h000A, 1, 0);
    pulse(1, 16'h000B, 0, 0);
    pulse(1, 16'h000C, 0, 0);
    pulse(1, 16'h000D, 0, 0);
    pulse(1, 16'h000E, 1, 0);
    pulse(0, 16'h0000, 0, 1);
    chk("c_error", 32'(error), 0);
    request(5'd0, 1, 10'd0, 16'h000A, 0, 0, 0);
    request(5'd1, 4, 10'd1, 16'h000B, 16'h000C, 16'h000D, 16'h000E);
    write_ready = 1; line = 16'h0055;
    @(posedge clk); #1;
    clear_in();
    chk("c_err_late_write", 32'(error), 1);
    @(posedge clk); #1;
    chk("c_no_late_we", 32'(mem_we), 0);

    // Short board: error raised, loaded lines still served.
    do_reset();
    n = 4'd2; m = 4'd3;
    pulse(1, 16'h0011, 1, 0);
    pulse(1, 16'h0022, 1, 0);
    pulse(1, 16'h0033, 1, 0);
    pulse(0, 16'h0000, 0, 1);
    chk("s_load_done", 32'(load_done), 1);
    chk("s_error", 32'(error), 1);
    request(5'd0, 1, 10'd0, 16'h0011, 0, 0, 0);
    request(5'd1, 1, 10'd1, 16'h0022, 0, 0, 0);
    request(5'd2, 1, 10'd2, 16'h0033, 0, 0, 0);
    request(5'd3, 0, 10'd0, 0, 0, 0, 0);

    // Reset in the middle of a stream, then reload.
    do_reset();
    load_board_a();
    req_valid = 1; req_line = 5'd3;
    w = 0;
    while (!req_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("r_req_ready", 32'(req_ready), 1);
    oq.push_back('{d: 16'h0001, l: 1'b0});
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("r_opt_valid", 32'(opt_valid), 0);
    chk("r_load_done", 32'(load_done), 0);
    chk("r_error", 32'(error), 0);
    chk("r_req_ready0", 32'(req_ready), 0);
    chk("r_state_idle", 32'(dut.state_q), 32'(S_IDLE));
    chk("r_opt_drained", 32'(oq.size()), 0);
    do_reset();
    load_board_a();
    requests_a();

    repeat (2) @(posedge clk);
    #1;
    chk("end_wq_empty", 32'(wq.size()), 0);
    chk("end_oq_empty", 32'(oq.size()), 0);
    chk("end_eq_empty", 32'(eq_n), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/option_store_ctrl.md
# option_store_ctrl

Controller between the parser and the line solver. It captures every option word the parser emits, writes it into a single-port option RAM, and builds a per-line base/count table. Once the board is loaded, it serves solver requests by streaming back all options of a requested line in order. It sequences the one option RAM through a LOAD phase and then a SERVE phase.

## Interface
- MAX_DIM, 11, maximum rows or columns; line table depth is 2*MAX_DIM
- OPT_W, 16, option word width, matches the parser `line` output
- ADDR_W, 10, option RAM address width
- CNT_W, 7, per-line option count width
- clk  in  1  single clock
- rst  in  1  reset, asynchronous, active-high
- write_ready  in  1  parser option-valid pulse
- line  in  OPT_W  option word, valid with write_ready
- line_done  in  1  parser end-of-line pulse
- board_done  in  1  parser end-of-board pulse
- n, m  in  4  row and column counts, stable before the first write_ready
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  OPT_W  RAM write data
- mem_rdata  in  OPT_W  RAM read data, valid 1 cycle after address
- req_valid, req_ready  in/out  1  solver line-request handshake
- req_line  in  5  requested line index: rows 0..n-1, then columns n..n+m-1
- opt_valid  out  1  streamed option valid
- opt_data  out  OPT_W  streamed option
- opt_last  out  1  final option of the line
- resp_empty  out  1  1-cycle pulse: line has zero options or the index is invalid
- load_done  out  1  level, high in SERVE phase
- error  out  1  sticky, cleared only by rst

## Operation
- States: IDLE, LOAD, READY, FETCH, STREAM.
- IDLE: wait for the first write_ready or line_done, then enter LOAD.
- LOAD:
  - On each write_ready, write `line` at wr_ptr, increment wr_ptr, and increment cnt[cur_line].
  - On line_done, cur_line++ and base[cur_line+1] = wr_ptr (post-increment value).
  - If write_ready and line_done occur in the same cycle, the option belongs to the current line and the line advances afterwards.
  - On board_done, go to READY. If cur_line != n+m, set error.
- READY: req_ready=1. When req_valid is accepted, latch req_line.
  - If req_line >= n+m or cnt==0: pulse resp_empty and stay in READY.
  - Otherwise go to FETCH.
- FETCH: drive mem_addr=base. Go to STREAM.
- STREAM: issue base+1 … base+cnt-1 on consecutive cycles. opt_valid follows each address by one cycle. opt_last accompanies the cnt-th option. After opt_last, return to READY.
- Overflow rules:
  - wr_ptr reaching 2^ADDR_W, cnt saturating at 2^CNT_W-1, or line_done beyond 2*MAX_DIM lines sets error.
  - Further writes are dropped (mem_we stays 0). Existing contents are kept.
- Parser pulses received in READY/FETCH/STREAM are ignored and set error.

## Timing
- Reset values: all outputs 0, state IDLE, wr_ptr=0, cur_line=0, base/cnt tables 0.
- mem_we, mem_addr, mem_wdata are registered, so the write lands 1 cycle after write_ready. Back-to-back write_ready every cycle is supported.
- load_done rises 1 cycle after board_done.
- Request latency: req accept at cycle T, mem_addr=base at T+1, first opt_valid at T+2, then one option per cycle with no gaps. A line with k options finishes with opt_last at T+1+k. req_ready is high again at T+2+k.
- resp_empty is asserted at T+1. req_ready is low during that cycle and returns high at T+2.
- req_ready is 0 outside READY. The solver must hold req_valid and req_line until accepted.
- rst mid-stream: outputs are cleared immediately (asynchronously). The table is invalid, and the parser must resend the board.

## Structure
- Shared package: state enum, MAX_DIM, OPT_W, ADDR_W, CNT_W, and the line-index type.
- Sub-module `line_table`: register file holding base[2*MAX_DIM] and cnt[2*MAX_DIM] (ADDR_W and CNT_W bits per entry), with one write/increment port and one read port.
- The controller FSM and pointers live in `option_store_ctrl`. The RAM is external.

## Test plan
- Load n=2, m=3. Row 0 gets option 16'h0007. Row 1 gets option 16'h0000. Columns 2–4 get options 16'h0001 and 16'h0002 each. Send board_done. -> mem writes at addresses 0..7 in that order; base={0,1,2,4,6}; cnt={1,1,2,2,2}; load_done=1; error=0.
- After load, request line 3. -> req accepted at T; opt_data 16'h0001 at T+2; 16'h0002 with opt_last at T+3; req_ready high at T+4.
- Request line 5 (>= n+m), and separately a zero-option line. -> resp_empty at T+1, no opt_valid, error unchanged.
- write_ready and line_done in the same cycle, followed by write_ready every cycle for 4 cycles. -> the combined option is counted in the old line; the next 4 options go to the new line at consecutive addresses.
- board_done after only 3 of 5 lines. -> READY entered, error=1. Requests for lines 0–2 still stream correctly.
- Assert rst during STREAM. -> opt_valid, load_done, and error are 0 immediately; state is IDLE; a reload of the same board reproduces the first scenario.
